// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between EX control and the iterative multiply/divide unit.
// Control drives start/op/A/B; the unit returns busy/done and the HI/LO registers.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit holding HI/LO.
// Shift-add multiply and restoring divide on sign-stripped magnitudes, one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    // Operand preparation at issue: even ops (MULT/DIV) are signed.
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.A[WIDTH-1];
    assign b_neg     = is_signed & bus.B[WIDTH-1];
    assign a_mag     = a_neg ? -bus.A : bus.A;
    assign b_mag     = b_neg ? -bus.B : bus.B;

    // Multiply step: acc = {partial high (W+1), multiplier/low product (W)}.
    logic [WIDTH:0]     mul_add, mul_sum;
    logic [2*WIDTH:0]   mul_next;

    assign mul_add  = acc_q[0] ? {1'b0, opnd_q} : '0;
    assign mul_sum  = acc_q[2*WIDTH:WIDTH] + mul_add;
    assign mul_next = {mul_sum, acc_q[WIDTH-1:0]} >> 1;

    // Divide step: acc = {remainder (W+1), dividend shifting out / quotient shifting in (W)}.
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH:0]   div_next;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift, acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff,  acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = qneg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    assign quo_fix  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        araw_d  = araw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.op[2]) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        op_d    = bus.op[1:0];
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        dz_d    = (bus.B == '0);
                        araw_d  = bus.A;
                        if (bus.op[1]) begin
                            acc_d  = {{(WIDTH+1){1'b0}}, a_mag};
                            opnd_d = b_mag;
                        end else begin
                            acc_d  = {{(WIDTH+1){1'b0}}, b_mag};
                            opnd_d = a_mag;
                        end
                    end else if (bus.op == 3'd4) begin
                        hi_d = bus.A;
                    end else if (bus.op == 3'd5) begin
                        lo_d = bus.A;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dz_q) begin
                    // Divide by zero reports the raw dividend, not its magnitude.
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            araw_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            araw_q  <= araw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_muldiv_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural HI/LO result of an arithmetic op.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0;
        lo = 32'h0;
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin
                if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            3'd3: begin
                if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Drive a one-cycle start; returns at the cycle-1 sample point.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd7;
    endtask

    // Walk cycles from c0 until done (bounded); stops at the done-cycle sample point.
    task automatic wait_done(input int c0, output int lat, output int busy_cnt);
        lat = c0;
        busy_cnt = 0;
        while (!bus.done && lat < 80) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'd7;
        bus.A = 32'h0;
        bus.B = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b required busy=0 done=0", bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo hi=%h lo=%h required 0/0", bus.hi, bus.lo);
        end
        $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    endtask

    task automatic test_directed;
        logic [2:0]  ops [6] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd3, 3'd2};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h1234, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] ehi [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'h1234, 32'h0};
        logic [31:0] elo [6] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(1, lat, bc);
            checks++;
            if (lat !== 34 || bc !== 33 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_timing[%0d] done_cycle=%0d busy_cycles=%0d busy=%b required 34/33/0",
                         i, lat, bc, bus.busy);
            end
            checks++;
            if (bus.hi !== ehi[i] || bus.lo !== elo[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] hi=%h lo=%h required hi=%h lo=%h",
                         i, bus.hi, bus.lo, ehi[i], elo[i]);
            end
            $display("directed op=%0d A=%h B=%h -> hi=%h lo=%h cycle=%0d", ops[i], as[i], bs[i], bus.hi, bus.lo, lat);
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b, ehi, elo;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'($urandom_range(0, 255));
                3: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            model(op, a, b, ehi, elo);
            issue(op, a, b);
            wait_done(1, lat, bc);
            checks++;
            if (lat !== 34 || bus.hi !== ehi || bus.lo !== elo) begin
                errors++;
                $display("FAIL random[%0d] op=%0d A=%h B=%h cycle=%0d hi=%h lo=%h required cycle=34 hi=%h lo=%h",
                         i, op, a, b, lat, bus.hi, bus.lo, ehi, elo);
            end
            $display("random op=%0d A=%h B=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
        end
        @(negedge clk);
    endtask

    task automatic test_move;
        logic [31:0] old_hi, old_lo;
        old_lo = bus.lo;
        issue(3'd4, 32'h55, 32'h0);
        checks++;
        if (bus.hi !== 32'h55 || bus.lo !== old_lo || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi hi=%h lo=%h done=%b busy=%b required hi=55 lo=%h done=0 busy=0",
                     bus.hi, bus.lo, bus.done, bus.busy, old_lo);
        end
        $display("mthi A=55 -> hi=%h lo=%h", bus.hi, bus.lo);
        issue(3'd5, 32'hCAFE_0001, 32'h0);
        checks++;
        if (bus.lo !== 32'hCAFE_0001 || bus.hi !== 32'h55 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo hi=%h lo=%h done=%b required hi=55 lo=cafe0001 done=0", bus.hi, bus.lo, bus.done);
        end
        $display("mtlo A=cafe0001 -> hi=%h lo=%h", bus.hi, bus.lo);
        old_hi = bus.hi;
        old_lo = bus.lo;
        issue(3'd6, 32'h1111, 32'h2222);
        issue(3'd7, 32'h3333, 32'h4444);
        checks++;
        if (bus.hi !== old_hi || bus.lo !== old_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL noop hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h busy=0 done=0",
                     bus.hi, bus.lo, bus.busy, bus.done, old_hi, old_lo);
        end
        $display("noop ops 6/7 -> hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_ignore_busy;
        logic [31:0] old_hi, old_lo;
        int lat, bc;
        old_hi = bus.hi;
        old_lo = bus.lo;
        issue(3'd1, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd5;
        bus.A = 32'hAA;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 3'd7;
        checks++;
        if (bus.hi !== old_hi || bus.lo !== old_lo || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold hi=%h lo=%h busy=%b required hi=%h lo=%h busy=1",
                     bus.hi, bus.lo, bus.busy, old_hi, old_lo);
        end
        wait_done(11, lat, bc);
        checks++;
        if (lat !== 34 || bus.lo !== 32'd30 || bus.hi !== 32'h0) begin
            errors++;
            $display("FAIL busy_ignore cycle=%0d hi=%h lo=%h required cycle=34 hi=0 lo=1e", lat, bus.hi, bus.lo);
        end
        $display("multu 5*6 with mtlo during busy -> hi=%h lo=%h cycle=%0d", bus.hi, bus.lo, lat);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(3'd3, 32'd1000, 32'd9);
        wait_done(1, lat, bc);
        // New op issued in the done cycle.
        issue(3'd0, 32'hFFFF_FFFE, 32'd50);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.lo !== 32'd111 || bus.hi !== 32'd1) begin
            errors++;
            $display("FAIL b2b_first done=%b busy=%b hi=%h lo=%h required done=0 busy=1 hi=1 lo=6f",
                     bus.done, bus.busy, bus.hi, bus.lo);
        end
        wait_done(1, lat, bc);
        checks++;
        if (lat !== 34 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FF9C) begin
            errors++;
            $display("FAIL b2b_second cycle=%0d hi=%h lo=%h required cycle=34 hi=ffffffff lo=ffffff9c",
                     lat, bus.hi, bus.lo);
        end
        $display("back-to-back divu 1000/9 then mult -2*50 -> hi=%h lo=%h", bus.hi, bus.lo);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen_done, seen_busy;
        issue(3'd4, 32'h77, 32'h0);
        issue(3'd3, 32'd12345, 32'd67);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h required busy=0 hi=0 lo=0", bus.busy, bus.hi, bus.lo);
        end
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen_done++;
            if (bus.busy) seen_busy++;
            @(negedge clk);
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0) begin
            errors++;
            $display("FAIL reset_abandon done_cycles=%0d busy_cycles=%0d required 0/0", seen_done, seen_busy);
        end
        issue(3'd0, 32'd2, 32'd3);
        wait_done(1, lat, bc);
        checks++;
        if (lat !== 34 || bus.lo !== 32'd6 || bus.hi !== 32'h0) begin
            errors++;
            $display("FAIL reset_recover cycle=%0d hi=%h lo=%h required cycle=34 hi=0 lo=6", lat, bus.hi, bus.lo);
        end
        $display("reset mid-divu then mult 2*3 -> hi=%h lo=%h cycle=%0d", bus.hi, bus.lo, lat);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_move();
        test_ignore_busy();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
